rb_on_g_interp: RTL and testbench

- Downstream consumer of the R/B-at-G difference-sum stage.
- Takes the centre green sample plus the four signed colour-difference sums gr_h, gr_v, gb_h and gb_v for each incoming Bayer pixel.
- Tracks pixel position within the frame and, at green sites, reconstructs the missing red and blue (equations 36-38: colour = G - diff/2), clamped to pixel range.
- Registered 2-stage pipeline with valid qualification and frame/line markers, feeding the demosaic output assembler.

---
 rtl/rb_on_g_interp_if.sv | 30 +++
 rtl/rb_on_g_interp.sv | 125 ++++++++++++
 tb/tb_rb_on_g_interp.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rb_on_g_interp_if.sv
// Pixel stream bundle between the difference-sum stage and the R/B-at-G interpolator.
// Carries the per-pixel inputs and the reconstructed RGB outputs with markers.
interface rb_on_g_interp_if #(
   parameter int pixelBitWidth = 12
);
   logic                       in_valid;
   logic                       in_sof;
   logic [pixelBitWidth-1:0]   g_c;
   logic signed [pixelBitWidth+1:0] gr_h;
   logic signed [pixelBitWidth+1:0] gr_v;
   logic signed [pixelBitWidth+1:0] gb_h;
   logic signed [pixelBitWidth+1:0] gb_v;
   logic                       out_valid;
   logic                       out_is_g;
   logic [pixelBitWidth-1:0]   r_out;
   logic [pixelBitWidth-1:0]   g_out;
   logic [pixelBitWidth-1:0]   b_out;
   logic                       out_sof;
   logic                       out_eol;

   modport master (
      output in_valid, in_sof, g_c, gr_h, gr_v, gb_h, gb_v,
      input  out_valid, out_is_g, r_out, g_out, b_out, out_sof, out_eol
   );

   modport slave (
      input  in_valid, in_sof, g_c, gr_h, gr_v, gb_h, gb_v,
      output out_valid, out_is_g, r_out, g_out, b_out, out_sof, out_eol
   );
endinterface

// File: rtl/rb_on_g_interp.sv
// Reconstructs missing red and blue at green Bayer sites as G - diff/2.
// Two registered stages: site decode + subtract, then clamp to pixel range.
module rb_on_g_interp #(
   parameter int pixelBitWidth = 12,
   parameter int IMG_WIDTH     = 640,
   parameter int IMG_HEIGHT    = 480,
   parameter int CFA_PATTERN   = 0
) (
   input logic             clk,
   input logic             rst,
   rb_on_g_interp_if.slave bus
);
   localparam int PW = pixelBitWidth;
   localparam int DW = PW + 2;
   localparam int AW = PW + 3;
   localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [1:0]    CFA      = 2'(CFA_PATTERN);
   localparam bit            RED_PH1  = (CFA_PATTERN < 2);

   logic [CW-1:0] col, pcol, ncol;
   logic [RW-1:0] row, prow, nrow;
   logic [1:0]    ph;
   logic          is_g, red_row;
   logic signed [DW-1:0] dr, db, hr, hb;
   logic signed [AW-1:0] g_x, r_raw, b_raw;

   logic                 v1, sof1, eol1, isg1;
   logic [PW-1:0]        g1;
   logic signed [AW-1:0] r1, b1;

   function automatic logic [PW-1:0] clamp(input logic signed [AW-1:0] x);
      if (x[AW-1])
         clamp = '0;
      else if (|x[AW-2:PW])
         clamp = '1;
      else
         clamp = x[PW-1:0];
   endfunction

   // Position of the current pixel and of the one after it; sof restarts at (0,0).
   always_comb begin
      pcol = bus.in_sof ? '0 : col;
      prow = bus.in_sof ? '0 : row;
      ncol = pcol + 1'b1;
      nrow = prow;
      if (pcol == COL_LAST) begin
         ncol = '0;
         nrow = (prow == ROW_LAST) ? '0 : prow + 1'b1;
      end
   end

   // Site decode and half-difference subtraction for the current pixel.
   always_comb begin
      ph      = CFA ^ {prow[0], pcol[0]};
      is_g    = (ph == 2'd1) || (ph == 2'd2);
      red_row = RED_PH1 ? (ph == 2'd1) : (ph == 2'd2);
      dr      = red_row ? bus.gr_h : bus.gr_v;
      db      = red_row ? bus.gb_v : bus.gb_h;
      hr      = dr >>> 1;
      hb      = db >>> 1;
      g_x     = $signed({3'b000, bus.g_c});
      r_raw   = g_x - {hr[DW-1], hr};
      b_raw   = g_x - {hb[DW-1], hb};
   end

   // Frame position counters advance once per accepted pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (bus.in_valid) begin
         col <= ncol;
         row <= nrow;
      end
   end

   // Stage 1 captures unclamped results; data holds across invalid cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1   <= 1'b0;
         sof1 <= 1'b0;
         eol1 <= 1'b0;
         isg1 <= 1'b0;
         g1   <= '0;
         r1   <= '0;
         b1   <= '0;
      end else begin
         v1 <= bus.in_valid;
         if (bus.in_valid) begin
            sof1 <= (pcol == '0) && (prow == '0);
            eol1 <= (pcol == COL_LAST);
            isg1 <= is_g;
            g1   <= bus.g_c;
            r1   <= r_raw;
            b1   <= b_raw;
         end
      end
   end

   // Stage 2 clamps to pixel range and zeroes R/B at non-green sites.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.out_is_g  <= 1'b0;
         bus.r_out     <= '0;
         bus.g_out     <= '0;
         bus.b_out     <= '0;
         bus.out_sof   <= 1'b0;
         bus.out_eol   <= 1'b0;
      end else begin
         bus.out_valid <= v1;
         if (v1) begin
            bus.out_is_g <= isg1;
            bus.r_out    <= isg1 ? clamp(r1) : '0;
            bus.b_out    <= isg1 ? clamp(b1) : '0;
            bus.g_out    <= g1;
            bus.out_sof  <= sof1;
            bus.out_eol  <= eol1;
         end
      end
   end
endmodule

// File: tb/tb_rb_on_g_interp.sv
// Bench for rb_on_g_interp: fixed vectors, corner sequences and random stream
// checked against a pixel-index based Bayer reference model.
module tb_rb_on_g_interp;
   localparam int PW   = 12;
   localparam int W    = 4;
   localparam int H    = 2;
   localparam int MAXV = (1 << PW) - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rb_on_g_interp_if #(.pixelBitWidth(PW)) bus ();

   rb_on_g_interp #(
      .pixelBitWidth(PW),
      .IMG_WIDTH(W),
      .IMG_HEIGHT(H),
      .CFA_PATTERN(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      bit v;
      bit isg;
      bit sof;
      bit eol;
      int r;
      int g;
      int b;
   } pix_t;

   typedef struct {
      bit s;
      int g;
      int grh;
      int grv;
      int gbh;
      int gbv;
      bit isg;
      int r;
      int b;
      bit sof;
      bit eol;
   } vec_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   p_idx  = 0;
   pix_t pend;
   pix_t shown;
   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int half(input int d);
      return (d >= 0) ? d / 2 : -((1 - d) / 2);
   endfunction

   function automatic int clampi(input int x);
      if (x < 0) return 0;
      if (x > MAXV) return MAXV;
      return x;
   endfunction

   // Reference: position from a linear pixel index, colours from the RGGB tile.
   function automatic pix_t predict(input bit s, input int g, input int grh,
                                    input int grv, input int gbh, input int gbv);
      pix_t  e;
      string cfa = "RGGB";
      int    pos, col, row, base;
      bit    red_row;
      pos     = s ? 0 : p_idx;
      col     = pos % W;
      row     = pos / W;
      base    = (row % 2) * 2;
      red_row = (cfa[base] == "R") || (cfa[base + 1] == "R");
      e.v     = 1'b1;
      e.sof   = (pos == 0);
      e.eol   = (col == W - 1);
      e.g     = g;
      e.isg   = (cfa[base + col % 2] == "G");
      e.r     = 0;
      e.b     = 0;
      if (e.isg) begin
         e.r = clampi(g - half(red_row ? grh : grv));
         e.b = clampi(g - half(red_row ? gbv : gbh));
      end
      return e;
   endfunction

   task automatic cmp_out(input string tag);
      chk({tag, "_valid"}, int'(bus.out_valid), int'(shown.v));
      chk({tag, "_is_g"}, int'(bus.out_is_g), int'(shown.isg));
      chk({tag, "_r"}, int'(bus.r_out), shown.r);
      chk({tag, "_g"}, int'(bus.g_out), shown.g);
      chk({tag, "_b"}, int'(bus.b_out), shown.b);
      chk({tag, "_sof"}, int'(bus.out_sof), int'(shown.sof));
      chk({tag, "_eol"}, int'(bus.out_eol), int'(shown.eol));
   endtask

   // One clock: drive inputs, advance the 2-deep model pipeline, check outputs.
   task automatic step(input bit v, input bit s, input int g, input int grh,
                       input int grv, input int gbh, input int gbv);
      pix_t e;
      e = '{default: 0};
      bus.in_valid = v;
      bus.in_sof   = s;
      bus.g_c      = g[PW-1:0];
      bus.gr_h     = grh[PW+1:0];
      bus.gr_v     = grv[PW+1:0];
      bus.gb_h     = gbh[PW+1:0];
      bus.gb_v     = gbv[PW+1:0];
      if (v) begin
         e     = predict(s, g, grh, grv, gbh, gbv);
         p_idx = ((s ? 0 : p_idx) + 1) % (W * H);
      end
      @(posedge clk);
      #1;
      if (pend.v)
         shown = pend;
      else
         shown.v = 1'b0;
      pend = e;
      cmp_out("model");
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 0, 0, 0);
   endtask

   task automatic reset_zero_check(input string tag);
      chk({tag, "_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_is_g"}, int'(bus.out_is_g), 0);
      chk({tag, "_r"}, int'(bus.r_out), 0);
      chk({tag, "_g"}, int'(bus.g_out), 0);
      chk({tag, "_b"}, int'(bus.b_out), 0);
      chk({tag, "_sof"}, int'(bus.out_sof), 0);
      chk({tag, "_eol"}, int'(bus.out_eol), 0);
   endtask

   // Asynchronous reset mid-cycle, then release just after the next edge.
   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      reset_zero_check("rst_async");
      pend  = '{default: 0};
      shown = '{default: 0};
      p_idx = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      pend         = '{default: 0};
      shown        = '{default: 0};
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.g_c      = '0;
      bus.gr_h     = '0;
      bus.gr_v     = '0;
      bus.gb_h     = '0;
      bus.gb_v     = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_zero_check("por");
      rst = 1'b1;

      // One full 4x2 RGGB frame, hand-computed expectations.
      tbl[0] = '{1, 500, 50, 60, 70, 80, 0, 0, 0, 1, 0};
      tbl[1] = '{0, 1000, -200, 7, 9, 100, 1, 1100, 950, 0, 0};
      tbl[2] = '{0, 123, 40, 41, 42, 43, 0, 0, 0, 0, 0};
      tbl[3] = '{0, 4000, -400, 5, 5, 100, 1, 4095, 3950, 0, 1};
      tbl[4] = '{0, 2000, 11, 300, -3, 13, 1, 1850, 2002, 1, 0};
      tbl[5] = '{0, 77, 1, 2, 3, 4, 0, 0, 0, 0, 0};
      tbl[6] = '{0, 10, -999, 0, 100, -999, 1, 10, 0, 0, 0};
      tbl[7] = '{0, 4095, -8, 8, -8, 8, 0, 0, 0, 0, 1};
      tbl[4].sof = 1'b0;

      for (int i = 0; i < 8; i++) begin
         step(1'b1, tbl[i].s, tbl[i].g, tbl[i].grh, tbl[i].grv,
              tbl[i].gbh, tbl[i].gbv);
         chk($sformatf("tbl%0d_gap", i), int'(bus.out_valid), 0);
         idle();
         chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), 1);
         chk($sformatf("tbl%0d_is_g", i), int'(bus.out_is_g), int'(tbl[i].isg));
         chk($sformatf("tbl%0d_r", i), int'(bus.r_out), tbl[i].r);
         chk($sformatf("tbl%0d_g", i), int'(bus.g_out), tbl[i].g);
         chk($sformatf("tbl%0d_b", i), int'(bus.b_out), tbl[i].b);
         chk($sformatf("tbl%0d_sof", i), int'(bus.out_sof), int'(tbl[i].sof));
         chk($sformatf("tbl%0d_eol", i), int'(bus.out_eol), int'(tbl[i].eol));
      end

      // Pixel 8 wraps to (0,0) without in_sof.
      step(1'b1, 1'b0, 321, 5, 5, 5, 5);
      idle();
      chk("wrap_sof", int'(bus.out_sof), 1);
      chk("wrap_is_g", int'(bus.out_is_g), 0);
      chk("wrap_g", int'(bus.g_out), 321);

      // in_sof at pixel 5 restarts the frame; next pixel is (0,1).
      step(1'b1, 1'b1, 100, 0, 0, 0, 0);
      for (int i = 1; i < 5; i++)
         step(1'b1, 1'b0, 100 + i, 0, 0, 0, 0);
      step(1'b1, 1'b1, 555, -200, 0, 0, 100);
      idle();
      chk("sof5_sof", int'(bus.out_sof), 1);
      chk("sof5_is_g", int'(bus.out_is_g), 0);
      chk("sof5_g", int'(bus.g_out), 555);
      step(1'b1, 1'b0, 1000, -200, 0, 0, 100);
      idle();
      chk("sof6_is_g", int'(bus.out_is_g), 1);
      chk("sof6_sof", int'(bus.out_sof), 0);
      chk("sof6_r", int'(bus.r_out), 1100);
      chk("sof6_b", int'(bus.b_out), 950);

      // Reset with data in both stages; no stale output afterwards.
      step(1'b1, 1'b0, 900, -100, -100, -100, -100);
      step(1'b1, 1'b0, 901, -100, -100, -100, -100);
      do_reset();
      idle();
      chk("post_rst_valid", int'(bus.out_valid), 0);
      step(1'b1, 1'b0, 700, -50, -50, -50, -50);
      chk("post_rst_gap", int'(bus.out_valid), 0);
      idle();
      chk("post_rst_valid2", int'(bus.out_valid), 1);
      chk("post_rst_sof", int'(bus.out_sof), 1);
      chk("post_rst_is_g", int'(bus.out_is_g), 0);
      chk("post_rst_r", int'(bus.r_out), 0);
      chk("post_rst_g", int'(bus.g_out), 700);

      // Random gapped stream with occasional frame restarts.
      for (int i = 0; i < 400; i++) begin
         bit v, s;
         v = ($urandom_range(99) < 70);
         s = v && ($urandom_range(99) < 4);
         step(v, s, int'($urandom_range(MAXV)),
              int'($urandom_range(16383)) - 8192,
              int'($urandom_range(16383)) - 8192,
              int'($urandom_range(16383)) - 8192,
              int'($urandom_range(16383)) - 8192);
      end
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
